// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus of the FIFO arbiter: requester grant handshake, memory write
// port drive, pointer outputs, and the consumer pop / status flags.
interface fifo_wr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PTR_WIDTH  = 3,
    parameter int unsigned NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         data_in;
    logic [PTR_WIDTH:0]            b_wptr;
    logic [PTR_WIDTH:0]            b_rptr;
    logic                          rd_en;
    logic                          full;
    logic                          empty;
    logic [PTR_WIDTH:0]            count;

    // Requesters, consumer and memory side
    modport master (
        output req,
        output req_data,
        output rd_en,
        input  gnt,
        input  w_en,
        input  data_in,
        input  b_wptr,
        input  b_rptr,
        input  full,
        input  empty,
        input  count
    );

    // Arbiter / pointer controller side
    modport slave (
        input  req,
        input  req_data,
        input  rd_en,
        output gnt,
        output w_en,
        output data_in,
        output b_wptr,
        output b_rptr,
        output full,
        output empty,
        output count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO memory write port among NUM_REQ
// requesters; owns the binary write/read pointers and full/empty/count.
module fifo_wr_arbiter #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PTR_WIDTH  = 3,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int unsigned PW1   = PTR_WIDTH + 1;
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (DEPTH != (32'd1 << PTR_WIDTH)) begin : g_depth_chk
        $error("fifo_wr_arbiter: DEPTH must equal 2**PTR_WIDTH");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_nreq_chk
        $error("fifo_wr_arbiter: NUM_REQ must be in 2..8");
    end

    logic [PW1-1:0]     wptr_q, wptr_d;
    logic [PW1-1:0]     rptr_q, rptr_d;
    logic [IDX_W-1:0]   last_q, last_d;

    logic               full_c;
    logic               empty_c;
    logic               pop_c;
    logic [NUM_REQ-1:0] gnt_c;
    logic               gnt_any_c;
    logic [IDX_W-1:0]   gnt_idx_c;
    int unsigned        scan_idx;
    logic [DATA_WIDTH-1:0] data_c;

    // Flags from registered pointers; extra MSB separates full from empty
    always_comb begin
        empty_c = (wptr_q == rptr_q);
        full_c  = (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) &&
                  (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0]);
        pop_c   = bus.rd_en && !empty_c;
    end

    // Round-robin search starting just after the last granted index
    always_comb begin
        gnt_c     = '0;
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        scan_idx  = 0;
        if (!rst && !full_c) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                scan_idx = (32'(last_q) + k) % NUM_REQ;
                if (!gnt_any_c && bus.req[scan_idx]) begin
                    gnt_any_c          = 1'b1;
                    gnt_idx_c          = IDX_W'(scan_idx);
                    gnt_c[scan_idx]    = 1'b1;
                end
            end
        end
    end

    // Write data mux: granted requester's slice, zero when idle
    always_comb begin
        data_c = '0;
        if (gnt_any_c) begin
            data_c = bus.req_data[32'(gnt_idx_c) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        wptr_d = wptr_q + PW1'(gnt_any_c);
        rptr_d = rptr_q + PW1'(pop_c);
        last_d = gnt_any_c ? gnt_idx_c : last_q;
    end

    // Reset leaves last at NUM_REQ-1 so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            last_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            last_q <= last_d;
        end
    end

    assign bus.gnt     = gnt_c;
    assign bus.w_en    = gnt_any_c;
    assign bus.data_in = data_c;
    assign bus.b_wptr  = wptr_q;
    assign bus.b_rptr  = rptr_q;
    assign bus.full    = full_c;
    assign bus.empty   = empty_c;
    assign bus.count   = wptr_q - rptr_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-based reference model with per-cycle
// comparison, directed scenarios with literal expectations, then random traffic.
module tb_fifo_wr_arbiter;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned PW    = 3;
    localparam int unsigned NR    = 4;
    localparam int unsigned PMOD  = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .NUM_REQ(NR)) bus ();

    fifo_wr_arbiter #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .PTR_WIDTH(PW), .NUM_REQ(NR)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory array fed by the DUT's write port
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.w_en === 1'b1) mem[bus.b_wptr[PW-1:0]] <= bus.data_in;
    end

    // Reference model: queue of stored entries plus total write/read counts
    logic [DW-1:0] q[$];
    int m_wcnt = 0;
    int m_rcnt = 0;
    int m_last = NR - 1;
    bit m_ok   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_grant(input logic [NR-1:0] r, input logic rs);
        if (rs || q.size() == DEPTH) return -1;
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (m_last + k) % NR;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            q.delete();
            m_wcnt = 0;
            m_rcnt = 0;
            m_last = NR - 1;
            m_ok   = 1'b1;
        end else if (m_ok) begin
            int g;
            g = exp_grant(bus.req, 1'b0);
            if (bus.rd_en && q.size() > 0) begin
                void'(q.pop_front());
                m_rcnt++;
            end
            if (g >= 0) begin
                q.push_back(bus.req_data[g*DW +: DW]);
                m_wcnt++;
                m_last = g;
            end
        end
    end

    // Per-cycle compare, mid-low phase after inputs settle
    always begin
        @(negedge clk);
        #2;
        if (m_ok) begin
            int g;
            logic [NR-1:0] eg;
            logic [DW-1:0] ed;
            g  = exp_grant(bus.req, rst);
            eg = '0;
            ed = '0;
            if (g >= 0) begin
                eg[g] = 1'b1;
                ed    = bus.req_data[g*DW +: DW];
            end
            chk("gnt",     32'(bus.gnt),     32'(eg));
            chk("w_en",    32'(bus.w_en),    32'(g >= 0));
            chk("data_in", 32'(bus.data_in), 32'(ed));
            chk("b_wptr",  32'(bus.b_wptr),  32'(m_wcnt % PMOD));
            chk("b_rptr",  32'(bus.b_rptr),  32'(m_rcnt % PMOD));
            chk("count",   32'(bus.count),   32'(q.size()));
            chk("full",    32'(bus.full),    32'(q.size() == DEPTH));
            chk("empty",   32'(bus.empty),   32'(q.size() == 0));
            if (q.size() > 0) chk("head", 32'(mem[m_rcnt % DEPTH]), 32'(q[0]));
        end
    end

    task automatic set_in(input logic rs, input logic [NR-1:0] r, input logic rd);
        @(negedge clk);
        rst        = rs;
        bus.req    = r;
        bus.rd_en  = rd;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] pend;
        rst          = 1'b1;
        bus.req      = 4'b1111;
        bus.rd_en    = 1'b1;
        bus.req_data = 32'h4433_2211;
        #1;
        chk("rst_gnt0", 32'(bus.gnt), 32'h0);

        // Reset held with requests and pops pending
        set_in(1'b1, 4'b1111, 1'b1);
        chk("rst_gnt",   32'(bus.gnt),    32'h0);
        chk("rst_empty", 32'(bus.empty),  32'h1);
        chk("rst_full",  32'(bus.full),   32'h0);
        chk("rst_count", 32'(bus.count),  32'h0);
        chk("rst_wptr",  32'(bus.b_wptr), 32'h0);
        chk("rst_rptr",  32'(bus.b_rptr), 32'h0);

        // Round robin from reset
        set_in(1'b0, 4'b1111, 1'b0);
        chk("rr_g0", 32'(bus.gnt), 32'b0001);
        chk("rr_d0", 32'(bus.data_in), 32'h11);
        set_in(1'b0, 4'b1111, 1'b0);
        chk("rr_g1", 32'(bus.gnt), 32'b0010);
        set_in(1'b0, 4'b1111, 1'b0);
        chk("rr_g2", 32'(bus.gnt), 32'b0100);
        set_in(1'b0, 4'b1111, 1'b0);
        chk("rr_g3", 32'(bus.gnt), 32'b1000);
        set_in(1'b0, 4'b0000, 1'b0);
        chk("rr_count", 32'(bus.count), 32'd4);
        chk("rr_m0", 32'(mem[0]), 32'h11);
        chk("rr_m1", 32'(mem[1]), 32'h22);
        chk("rr_m2", 32'(mem[2]), 32'h33);
        chk("rr_m3", 32'(mem[3]), 32'h44);

        // Fill to full with requester 0
        set_in(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 4'b0001, 1'b0);
            bus.req_data[7:0] = 8'(8'hA0 + i);
        end
        set_in(1'b0, 4'b0001, 1'b0);
        chk("fill_full",  32'(bus.full),   32'h1);
        chk("fill_count", 32'(bus.count),  32'd8);
        chk("fill_wptr",  32'(bus.b_wptr), 32'b1000);
        chk("fill_rptr",  32'(bus.b_rptr), 32'h0);
        chk("fill_gnt9",  32'(bus.gnt),    32'h0);
        set_in(1'b0, 4'b0100, 1'b1);
        chk("fullpop_gnt", 32'(bus.gnt),    32'h0);
        chk("fullpop_wp",  32'(bus.b_wptr), 32'b1000);
        set_in(1'b0, 4'b0100, 1'b0);
        chk("fullpop_gnt2", 32'(bus.gnt),    32'b0100);
        chk("fullpop_rptr", 32'(bus.b_rptr), 32'h1);
        set_in(1'b0, 4'b0000, 1'b0);
        chk("fullpop_cnt",  32'(bus.count),  32'd8);
        chk("fullpop_wptr", 32'(bus.b_wptr), 32'b1001);

        // Streaming with wrap-around
        set_in(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst               = 1'b0;
            bus.req           = 4'b0001;
            bus.rd_en         = (i > 0);
            bus.req_data[7:0] = DW'($urandom);
            #1;
            if (i == 12) chk("wrap_count", 32'(bus.count), 32'd1);
        end
        set_in(1'b0, 4'b0000, 1'b1);
        set_in(1'b0, 4'b0000, 1'b1);
        chk("wrap_empty", 32'(bus.empty),  32'h1);
        chk("wrap_rptr",  32'(bus.b_rptr), 32'd4);
        set_in(1'b0, 4'b0000, 1'b0);
        chk("wrap_rptr2", 32'(bus.b_rptr), 32'd4);
        chk("wrap_wptr",  32'(bus.b_wptr), 32'd4);

        // Reset mid-operation
        set_in(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) set_in(1'b0, 4'b0001, 1'b0);
        set_in(1'b1, 4'b0110, 1'b0);
        chk("mid_cnt5", 32'(bus.count), 32'd5);
        chk("mid_gnt",  32'(bus.gnt),   32'h0);
        set_in(1'b0, 4'b0110, 1'b0);
        chk("mid_count", 32'(bus.count), 32'h0);
        chk("mid_empty", 32'(bus.empty), 32'h1);
        chk("mid_gnt2",  32'(bus.gnt),   32'b0010);

        // Random traffic: requesters hold req and data until granted
        pend = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 4) begin
                    pend[i] = 1'b1;
                    bus.req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            rst       = ($urandom_range(0, 99) == 0);
            bus.req   = pend;
            bus.rd_en = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) < 7);
            #1;
            if (!rst) pend = pend & ~bus.gnt;
        end
        set_in(1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Single-clock write-side arbiter and pointer controller for the FIFO memory array. Shares the memory's one write port among NUM_REQ requesters with round-robin fairness. Owns the binary write/read pointers, the full/empty flags and the occupancy count. Drives the memory's `w_en`, `data_in`, `b_wptr` and `b_rptr` directly; one consumer pops the head entry through the memory's combinational read port.

## Interface
Parameters:
- DEPTH, 8, number of memory entries; must equal 2**PTR_WIDTH
- DATA_WIDTH, 8, entry width in bits
- PTR_WIDTH, 3, address bits; pointers carry one extra wrap bit
- NUM_REQ, 4, number of write requesters (2..8)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester write request; requester holds req and data until granted
- req_data  in  NUM_REQ*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
- gnt  out  NUM_REQ  one-hot (or zero) grant; combinational; write accepted on the edge where gnt[i]=1
- w_en  out  1  memory write enable, = |gnt
- data_in  out  DATA_WIDTH  req_data slice of granted requester; all-zero when no grant
- b_wptr  out  PTR_WIDTH+1  registered binary write pointer
- b_rptr  out  PTR_WIDTH+1  registered binary read pointer
- rd_en  in  1  consumer pop of head entry
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- count  out  PTR_WIDTH+1  occupancy, 0..DEPTH

## Operation
- Pointers:
  - Both pointers are (PTR_WIDTH+1)-bit binary and wrap modulo 2**(PTR_WIDTH+1).
  - Memory is addressed by the low PTR_WIDTH bits.
- Flags (combinational from registered pointers):
  - empty = (b_wptr == b_rptr).
  - full = MSBs differ AND low PTR_WIDTH bits equal.
  - count = b_wptr − b_rptr, mod 2**(PTR_WIDTH+1).
- Arbitration:
  - A `last` register holds the index of the most recent grant.
  - Search order starts at (last+1) mod NUM_REQ and wraps.
  - The first index with req=1 is granted.
  - No grant when full=1 or rst=1.
  - `last` updates only on cycles with a grant.
- Write: on a grant, the memory captures data_in at b_wptr and b_wptr increments by 1.
- Read:
  - rd_en=1 with empty=0 increments b_rptr.
  - rd_en while empty is ignored (no pointer change, no error).
- Simultaneous write and pop, neither full nor empty: both pointers advance; count unchanged.
- Write blocked while full, even when rd_en=1 in the same cycle. Space frees on the next edge and the write is granted the following cycle.
- Pop permitted while full; write permitted while empty. Head data is valid only after the write edge.
- Fairness: a requester holding req is granted within NUM_REQ grant cycles.
- Reset mid-operation:
  - All state clears on the rst edge.
  - Queued contents are discarded logically; memory contents are not cleared.
  - Requesters whose grant was suppressed by rst must keep req asserted.

## Timing
- Reset values (after the rst edge):
  - b_wptr=0, b_rptr=0, count=0.
  - empty=1, full=0.
  - `last`=NUM_REQ−1, so requester 0 has first priority.
  - gnt=0, w_en=0, data_in=0 while rst=1.
- Grant latency:
  - Zero cycles: gnt is valid in the same cycle req rises, provided full=0.
  - The write commits on that cycle's posedge.
- Flag latency: full, empty and count reflect a write or pop in the cycle after its edge.
- Pop-to-data: after the edge with rd_en=1, the memory output shows the next entry combinationally.
- Throughput: one write and one pop per cycle, sustained.

## Test plan
- **Reset/idle:** assert rst 2 cycles with req=4'b1111 and rd_en=1 → gnt=0, empty=1, full=0, count=0, pointers 0 throughout.
- **Round robin:** hold req=4'b1111 for 4 cycles from reset with rd_en=0 → gnt sequence 0001, 0010, 0100, 1000; memory entries 0..3 hold each requester's data; count=4.
- **Fill to full:**
  - Write 8 entries with req=4'b0001 only → full=1, count=8, b_wptr=4'b1000, b_rptr=0.
  - 9th request → gnt=0 and no pointer change.
- **Full with pop:**
  - At full, rd_en=1 with req[2]=1 → write blocked that cycle.
  - Next cycle gnt=4'b0100; count returns to 8; b_rptr=1, b_wptr=4'b1001.
- **Wrap-around:**
  - Stream 20 writes with a simultaneous pop each cycle after the first.
  - Pointers wrap past 15→0; count stays 1; data out matches write order.
  - Pop on empty at the end → b_rptr unchanged.
- **Reset mid-operation:** with count=5 and req=4'b0110, pulse rst for one cycle → next cycle count=0, empty=1, and gnt=4'b0010 (priority restarts at requester 0).
